// File: rtl/relobi_outstanding_limiter.sv
// Caps the number of outstanding OBI transactions between an upstream port and a cut stage.
// The outstanding count is triplicated and majority-voted so one upset replica is scrubbed every cycle.
module relobi_outstanding_limiter #(
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sbr_req_i,
  input  logic [AddrWidth-1:0]   sbr_addr_i,
  input  logic                   sbr_we_i,
  input  logic [DataWidth/8-1:0] sbr_be_i,
  input  logic [DataWidth-1:0]   sbr_wdata_i,
  output logic                   sbr_gnt_o,
  output logic                   sbr_rvalid_o,
  output logic [DataWidth-1:0]   sbr_rdata_o,
  output logic                   sbr_err_o,
  input  logic                   sbr_rready_i,
  output logic                   mgr_req_o,
  output logic [AddrWidth-1:0]   mgr_addr_o,
  output logic                   mgr_we_o,
  output logic [DataWidth/8-1:0] mgr_be_o,
  output logic [DataWidth-1:0]   mgr_wdata_o,
  input  logic                   mgr_gnt_i,
  input  logic                   mgr_rvalid_i,
  input  logic [DataWidth-1:0]   mgr_rdata_i,
  input  logic                   mgr_err_i,
  output logic                   mgr_rready_o,
  output logic                   idle_o,
  output logic [1:0]             fault_o
);

  localparam int unsigned         CntWidth = $clog2(MaxTrans + 1);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxTrans);

  logic [CntWidth-1:0] cnt_q [3];
  logic [CntWidth-1:0] cnt_d;
  logic [CntWidth-1:0] cnt_v;
  logic [1:0]          fault_q, fault_d;
  logic                full, cnt_zero, inc, dec, mismatch;

  assign cnt_v    = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
  assign full     = (cnt_v == CntMax);
  assign cnt_zero = (cnt_v == '0);

  assign mgr_req_o    = sbr_req_i & ~full;
  assign sbr_gnt_o    = mgr_gnt_i & ~full;
  assign mgr_addr_o   = sbr_addr_i;
  assign mgr_we_o     = sbr_we_i;
  assign mgr_be_o     = sbr_be_i;
  assign mgr_wdata_o  = sbr_wdata_i;

  assign sbr_rvalid_o = mgr_rvalid_i;
  assign sbr_rdata_o  = mgr_rdata_i;
  assign sbr_err_o    = mgr_err_i;
  assign mgr_rready_o = sbr_rready_i;

  assign inc = mgr_req_o & mgr_gnt_i;
  assign dec = mgr_rvalid_i & sbr_rready_i;

  assign idle_o  = cnt_zero;
  assign fault_o = fault_q;

  always_comb begin
    cnt_d = cnt_v;
    if (inc && !dec) begin
      cnt_d = cnt_v + CntWidth'(1);
    end else if (dec && !inc && !cnt_zero) begin
      cnt_d = cnt_v - CntWidth'(1);
    end else if (inc && dec && cnt_zero) begin
      // a response with nothing outstanding cannot retire the transaction granted this cycle
      cnt_d = CntWidth'(1);
    end
    mismatch = (cnt_q[0] != cnt_v) | (cnt_q[1] != cnt_v) | (cnt_q[2] != cnt_v);
    fault_d  = {dec & cnt_zero & ~inc, mismatch};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      cnt_q[2] <= '0;
      fault_q  <= 2'b00;
    end else begin
      cnt_q[0] <= cnt_d;
      cnt_q[1] <= cnt_d;
      cnt_q[2] <= cnt_d;
      fault_q  <= fault_d;
    end
  end

endmodule
